// File: rtl/uart_shell_pkg.sv
// Shared definitions for the UART command shell: FSM and opcode encodings,
// ASCII constants, default buffer layout and command keyword tables.
package uart_shell_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEC,
        ST_XFER,
        ST_ERR,
        ST_TAIL,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_UP,
        OP_REV,
        OP_ERR
    } op_t;

    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_LF       = 8'h0A;
    localparam logic [7:0] ASCII_BS       = 8'h08;
    localparam logic [7:0] ASCII_SPACE    = 8'h20;
    localparam logic [7:0] ASCII_A_LO     = 8'h61;
    localparam logic [7:0] ASCII_Z_LO     = 8'h7A;
    localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

    localparam int DEFAULT_LEN        = 256;
    localparam int DEFAULT_RXSTR_BASE = 0;
    localparam int DEFAULT_TXSTR_BASE = 128;

    // Keyword bytes "up " and "rev "; the unused fourth "up" slot never takes part in a match.
    function automatic logic [7:0] up_keyword(input logic [1:0] k);
        case (k)
            2'd0:    return 8'h75;
            2'd1:    return 8'h70;
            default: return ASCII_SPACE;
        endcase
    endfunction

    function automatic logic [7:0] rev_keyword(input logic [1:0] k);
        case (k)
            2'd0:    return 8'h72;
            2'd1:    return 8'h65;
            2'd2:    return 8'h76;
            default: return ASCII_SPACE;
        endcase
    endfunction

    function automatic logic [7:0] err_text(input logic [1:0] k);
        return (k == 2'd0) ? 8'h45 : 8'h52;
    endfunction

endpackage

// File: rtl/uart_char_xform.sv
// Per-character mapping applied while copying a command argument into the
// response buffer; purely combinational.
module uart_char_xform
    import uart_shell_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] char_in,
    output logic [WIDTH-1:0] char_out
);

    always_comb begin
        char_out = char_in;
        if (op == OP_UP && char_in >= WIDTH'(ASCII_A_LO) && char_in <= WIDTH'(ASCII_Z_LO)) begin
            char_out = char_in - WIDTH'(ASCII_CASE_OFS);
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Decodes a command line from the RX region of the shared line RAM, executes
// it and writes the CR LF terminated response into the TX region.
module uart_cmd_responder
    import uart_shell_pkg::*;
#(
    parameter int  WIDTH      = 8,
    parameter int  LEN        = DEFAULT_LEN,
    parameter int  RXSTR_BASE = DEFAULT_RXSTR_BASE,
    parameter int  TXSTR_BASE = DEFAULT_TXSTR_BASE,
    parameter int  TX_CAP     = LEN - TXSTR_BASE,
    localparam int AW         = $clog2(LEN - 1) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [AW-1:0]    cmd_len,
    output logic             msg_valid,
    output logic [AW-1:0]    msg_len,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_din,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_dout,
    output logic             busy
);

    localparam logic [AW-1:0] RX_BASE = AW'(RXSTR_BASE);
    localparam logic [AW-1:0] TX_BASE = AW'(TXSTR_BASE);
    localparam logic [AW-1:0] MAX_N   = AW'(TX_CAP - 2);

    state_t           state;
    op_t              op;
    op_t              dec_op;
    logic [AW-1:0]    len;
    logic [AW-1:0]    n;
    logic [AW-1:0]    dec_n;
    logic [AW-1:0]    idx;
    logic [AW-1:0]    next_src;
    logic [2:0]       dec_cnt;
    logic [1:0]       dec_k;
    logic             match_up;
    logic             match_rev;
    logic             wr_phase;
    logic             lf_phase;
    logic             xfer_wr;
    logic [WIDTH-1:0] din_reg;
    logic [WIDTH-1:0] xform_out;

    function automatic logic [AW-1:0] clamp_n(input logic [AW-1:0] v);
        return (v > MAX_N) ? MAX_N : v;
    endfunction

    uart_char_xform #(
        .WIDTH(WIDTH)
    ) u_xform (
        .op      (op),
        .char_in (mem_dout),
        .char_out(xform_out)
    );

    // Copied characters come straight from the RAM read port during the write cycle.
    assign mem_din = xfer_wr ? xform_out : din_reg;
    assign dec_k   = dec_cnt[1:0] - 2'd1;

    always_comb begin
        next_src = RX_BASE + AW'(3) + idx + AW'(1);
        if (op == OP_REV) begin
            next_src = RX_BASE + len - AW'(1) - (idx + AW'(1));
        end
    end

    // Final verdict in the last DEC cycle, when byte 3 is on mem_dout.
    always_comb begin
        dec_op = OP_ERR;
        dec_n  = '0;
        if (len >= AW'(3) && match_up) begin
            dec_op = OP_UP;
            dec_n  = clamp_n(len - AW'(3));
        end else if (len >= AW'(4) && match_rev && mem_dout == WIDTH'(ASCII_SPACE)) begin
            dec_op = OP_REV;
            dec_n  = clamp_n(len - AW'(4));
        end else if (len == '0) begin
            dec_op = OP_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op        <= OP_NONE;
            len       <= '0;
            n         <= '0;
            idx       <= '0;
            dec_cnt   <= '0;
            match_up  <= 1'b0;
            match_rev <= 1'b0;
            wr_phase  <= 1'b0;
            lf_phase  <= 1'b0;
            xfer_wr   <= 1'b0;
            din_reg   <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            msg_valid <= 1'b0;
            msg_len   <= '0;
            busy      <= 1'b0;
        end else begin
            msg_valid <= 1'b0;
            mem_we    <= 1'b0;
            xfer_wr   <= 1'b0;
            din_reg   <= '0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        len       <= cmd_len;
                        busy      <= 1'b1;
                        dec_cnt   <= '0;
                        match_up  <= 1'b1;
                        match_rev <= 1'b1;
                        mem_addr  <= RX_BASE;
                        state     <= ST_DEC;
                    end
                end
                ST_DEC: begin
                    dec_cnt <= dec_cnt + 3'd1;
                    if (dec_cnt < 3'd3) begin
                        mem_addr <= RX_BASE + AW'(dec_cnt) + AW'(1);
                    end
                    if (dec_cnt != 3'd0 && dec_cnt < 3'd4) begin
                        match_up  <= match_up  & (dec_k == 2'd3 || mem_dout == WIDTH'(up_keyword(dec_k)));
                        match_rev <= match_rev & (mem_dout == WIDTH'(rev_keyword(dec_k)));
                    end
                    if (dec_cnt == 3'd4) begin
                        op       <= dec_op;
                        idx      <= '0;
                        wr_phase <= 1'b0;
                        if (dec_op == OP_ERR) begin
                            n        <= AW'(3);
                            mem_addr <= TX_BASE;
                            din_reg  <= WIDTH'(err_text(2'd0));
                            mem_we   <= 1'b1;
                            state    <= ST_ERR;
                        end else if (dec_n == '0) begin
                            n        <= '0;
                            lf_phase <= 1'b0;
                            mem_addr <= TX_BASE;
                            din_reg  <= WIDTH'(ASCII_CR);
                            mem_we   <= 1'b1;
                            state    <= ST_TAIL;
                        end else begin
                            n        <= dec_n;
                            mem_addr <= (dec_op == OP_UP) ? RX_BASE + AW'(3) : RX_BASE + len - AW'(1);
                            state    <= ST_XFER;
                        end
                    end
                end
                ST_XFER: begin
                    if (!wr_phase) begin
                        wr_phase <= 1'b1;
                        mem_addr <= TX_BASE + idx;
                        mem_we   <= 1'b1;
                        xfer_wr  <= 1'b1;
                    end else begin
                        wr_phase <= 1'b0;
                        idx      <= idx + AW'(1);
                        if (idx + AW'(1) == n) begin
                            lf_phase <= 1'b0;
                            mem_addr <= TX_BASE + n;
                            din_reg  <= WIDTH'(ASCII_CR);
                            mem_we   <= 1'b1;
                            state    <= ST_TAIL;
                        end else begin
                            mem_addr <= next_src;
                        end
                    end
                end
                ST_ERR: begin
                    mem_we <= 1'b1;
                    if (idx == AW'(2)) begin
                        lf_phase <= 1'b0;
                        mem_addr <= TX_BASE + AW'(3);
                        din_reg  <= WIDTH'(ASCII_CR);
                        state    <= ST_TAIL;
                    end else begin
                        idx      <= idx + AW'(1);
                        mem_addr <= TX_BASE + idx + AW'(1);
                        din_reg  <= WIDTH'(err_text(2'(idx + AW'(1))));
                    end
                end
                ST_TAIL: begin
                    if (!lf_phase) begin
                        lf_phase <= 1'b1;
                        mem_addr <= TX_BASE + n + AW'(1);
                        din_reg  <= WIDTH'(ASCII_LF);
                        mem_we   <= 1'b1;
                    end else begin
                        msg_valid <= 1'b1;
                        msg_len   <= n + AW'(2);
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
